// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler for the 96 MHz phase-accumulator NCO: steps upr from f_start to f_stop.
// Optional NCO_SWEEP_PHASE_RST_EN adds nco_rst, pulsed whenever upr is loaded with f_start.
module nco_sweep_ctrl #(
  parameter int unsigned       FREQ_W    = 32,
  parameter int unsigned       DWELL_W   = 24,
  parameter logic [FREQ_W-1:0] IDLE_FREQ = FREQ_W'(1000000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [FREQ_W-1:0]  cfg_f_start,
  input  logic [FREQ_W-1:0]  cfg_f_stop,
  input  logic [FREQ_W-1:0]  cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [FREQ_W-1:0]  upr,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic [15:0]        hop_cnt
`ifdef NCO_SWEEP_PHASE_RST_EN
  ,
  output logic               nco_rst
`endif
);

  localparam int unsigned HOP_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP} state_t;

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  upr_d;
  logic               busy_d, done_d, wrap_d;
  logic [HOP_W-1:0]   hop_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [FREQ_W-1:0]  f_start_q, f_start_d, f_stop_q, f_stop_d, f_step_q, f_step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               repeat_q, repeat_d;
  logic               dir_down_q, dir_down_d;
`ifdef NCO_SWEEP_PHASE_RST_EN
  logic               nco_rst_d;
`endif

  // Config as seen on a start edge: a same-edge cfg_we takes effect immediately
  logic [FREQ_W-1:0]  eff_start, eff_stop;
  logic [DWELL_W-1:0] eff_dwell;

  assign eff_start = cfg_we ? cfg_f_start : f_start_q;
  assign eff_stop  = cfg_we ? cfg_f_stop  : f_stop_q;
  assign eff_dwell = cfg_we ? cfg_dwell   : dwell_q;

  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // Next point in FREQ_W+1 bits so carry/borrow shows up as overshoot
  logic [FREQ_W:0]   sum_up, diff_dn;
  logic              over_up, over_dn, is_last;
  logic [FREQ_W-1:0] next_freq;

  assign sum_up    = {1'b0, upr} + {1'b0, f_step_q};
  assign diff_dn   = {1'b0, upr} - {1'b0, f_step_q};
  assign over_up   = sum_up[FREQ_W]  || (sum_up[FREQ_W-1:0]  > f_stop_q);
  assign over_dn   = diff_dn[FREQ_W] || (diff_dn[FREQ_W-1:0] < f_stop_q);
  assign next_freq = dir_down_q ? (over_dn ? f_stop_q : diff_dn[FREQ_W-1:0])
                                : (over_up ? f_stop_q : sum_up[FREQ_W-1:0]);
  assign is_last   = (upr == f_stop_q) || (f_step_q == '0);

  always_comb begin
    state_d     = state_q;
    upr_d       = upr;
    busy_d      = busy;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    hop_d       = hop_cnt;
    dwell_cnt_d = dwell_cnt_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;
    repeat_d    = repeat_q;
    dir_down_d  = dir_down_q;
`ifdef NCO_SWEEP_PHASE_RST_EN
    nco_rst_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          f_start_d = cfg_f_start;
          f_stop_d  = cfg_f_stop;
          f_step_d  = cfg_f_step;
          dwell_d   = cfg_dwell;
          repeat_d  = cfg_repeat;
        end
        if (start && !abort) begin
          state_d     = S_DWELL;
          upr_d       = eff_start;
          hop_d       = '0;
          dwell_cnt_d = dwell_reload(eff_dwell);
          busy_d      = 1'b1;
          dir_down_d  = (eff_stop < eff_start);
`ifdef NCO_SWEEP_PHASE_RST_EN
          nco_rst_d   = 1'b1;
`endif
        end
      end

      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (dwell_cnt_q == '0) begin
          // A single-shot sweep ends straight from the final dwell, without a STEP cycle
          if (is_last && !repeat_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end

      S_STEP: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (is_last) begin
          if (repeat_q) begin
            state_d     = S_DWELL;
            wrap_d      = 1'b1;
            upr_d       = f_start_q;
            hop_d       = '0;
            dwell_cnt_d = dwell_reload(dwell_q);
`ifdef NCO_SWEEP_PHASE_RST_EN
            nco_rst_d   = 1'b1;
`endif
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d     = S_DWELL;
          upr_d       = next_freq;
          hop_d       = (hop_cnt == '1) ? hop_cnt : hop_cnt + HOP_W'(1);
          dwell_cnt_d = dwell_reload(dwell_q);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      upr         <= IDLE_FREQ;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap        <= 1'b0;
      hop_cnt     <= '0;
      dwell_cnt_q <= '0;
      f_start_q   <= IDLE_FREQ;
      f_stop_q    <= IDLE_FREQ;
      f_step_q    <= '0;
      dwell_q     <= DWELL_W'(1);
      repeat_q    <= 1'b0;
      dir_down_q  <= 1'b0;
`ifdef NCO_SWEEP_PHASE_RST_EN
      nco_rst     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      upr         <= upr_d;
      busy        <= busy_d;
      done        <= done_d;
      wrap        <= wrap_d;
      hop_cnt     <= hop_d;
      dwell_cnt_q <= dwell_cnt_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
      repeat_q    <= repeat_d;
      dir_down_q  <= dir_down_d;
`ifdef NCO_SWEEP_PHASE_RST_EN
      nco_rst     <= nco_rst_d;
`endif
    end
  end

endmodule
